// File: rtl/usr_serial_tx_ctrl.sv
// Parallel-in/serial-out sequencer for universal_shift_register: loads each accepted word,
// then shifts it out one bit per serial handshake, with stall, abort and flush handling.
module usr_serial_tx_ctrl #(
  parameter int N    = 8,
  parameter bit DIR  = 1'b0,
  parameter bit FILL = 1'b0
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_data,
  output logic         ser_last,
  output logic         busy,
  output logic         usr_enable,
  output logic         usr_s1,
  output logic         usr_s0,
  output logic         usr_msb_in,
  output logic         usr_lsb_in,
  output logic         usr_clear,
  output logic [N-1:0] usr_I,
  input  logic [N-1:0] usr_Q,
  output logic [1:0]   state_dbg
);

  localparam logic [1:0] FLUSH = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;

  localparam int              CW       = $clog2(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [N-1:0]    OUT_MASK = DIR ? {1'b1, {(N-1){1'b0}}} : {{(N-1){1'b0}}, 1'b1};

  // Handshakes: a word moves when in_valid && in_ready at a rising edge; a bit moves when
  // ser_valid && ser_ready. in_ready never looks at in_valid, ser_valid never looks at ser_ready.
  logic [1:0]    state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [N-1:0]  hold, next_hold;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= FLUSH;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      hold  <= next_hold;
    end
  end

  assign state_dbg  = state;
  assign usr_I      = hold;
  assign usr_msb_in = FILL;
  assign usr_lsb_in = FILL;
  // The outgoing bit sits at the end of the register that is about to be shifted away.
  assign ser_data   = |(usr_Q & OUT_MASK);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_hold  = hold;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b1;
    usr_enable = 1'b0;
    usr_s1     = 1'b0;
    usr_s0     = 1'b0;
    usr_clear  = 1'b0;
    case (state)
      FLUSH: begin
        usr_enable = 1'b1;
        usr_clear  = 1'b1;
        next_cnt   = '0;
        next_state = IDLE;
      end
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          next_hold  = in_data;
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_cnt = '0;
        if (abort) begin
          next_state = FLUSH;
        end else begin
          usr_enable = 1'b1;
          usr_s1     = 1'b1;
          usr_s0     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          next_cnt   = '0;
          next_state = FLUSH;
        end else begin
          ser_valid = 1'b1;
          ser_last  = (cnt == CNT_LAST);
          // A stalled beat leaves the register untouched so the same bit is offered again.
          if (ser_ready) begin
            usr_enable = 1'b1;
            usr_s1     = DIR;
            usr_s0     = ~DIR;
            if (cnt == CNT_LAST) begin
              next_cnt   = '0;
              next_state = IDLE;
            end else begin
              next_cnt = cnt + CW'(1);
            end
          end
        end
      end
      default: next_state = FLUSH;
    endcase
  end

endmodule
